ysyx_22040750_axi_rd_arbiter_n: RTL and testbench

- N-channel AXI4 read-only arbiter. Funnels NUM_CH upstream masters (ICache, DCache, DMA, ...) onto one downstream AR/R port.
- Round-robin grant. A grant is locked from AR acceptance until the RLAST beat of that burst.
- Counts burst beats against ARLEN and flags protocol mismatches.
- Successor to the two-channel fixed-width crossbar; sits between the cache masters and the AXI memory bridge.

---
 rtl/ysyx_22040750_axi_rd_arbiter_n.sv | 206 ++++++++++++++++++++
 tb/tb_ysyx_22040750_axi_rd_arbiter_n.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040750_axi_rd_arbiter_n.sv
// N-channel AXI4 read arbiter: round-robin grant across NUM_CH upstream
// masters onto one downstream AR/R port. One burst is in flight at a time,
// and the grant stays locked from AR acceptance until the RLAST handshake.
// Beats are counted against ARLEN, and any mismatch sets a sticky flag.
module ysyx_22040750_axi_rd_arbiter_n #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     I_clk,
  input  logic                     I_rst_n,
  input  logic [NUM_CH-1:0]        I_ch_arvalid,
  output logic [NUM_CH-1:0]        O_ch_arready,
  input  logic [NUM_CH*ADDR_W-1:0] I_ch_araddr,
  input  logic [NUM_CH*8-1:0]      I_ch_arlen,
  input  logic [NUM_CH*3-1:0]      I_ch_arsize,
  input  logic [NUM_CH*2-1:0]      I_ch_arburst,
  output logic [NUM_CH-1:0]        O_ch_rvalid,
  input  logic [NUM_CH-1:0]        I_ch_rready,
  output logic [DATA_W-1:0]        O_ch_rdata,
  output logic [NUM_CH-1:0]        O_ch_rlast,
  output logic                     O_axi_arvalid,
  input  logic                     I_axi_arready,
  output logic [ADDR_W-1:0]        O_axi_araddr,
  output logic [7:0]               O_axi_arlen,
  output logic [2:0]               O_axi_arsize,
  output logic [1:0]               O_axi_arburst,
  input  logic                     I_axi_rvalid,
  output logic                     O_axi_rready,
  input  logic [DATA_W-1:0]        I_axi_rdata,
  input  logic                     I_axi_rlast,
  output logic                     O_busy,
  output logic [CH_W-1:0]          O_grant,
  output logic                     O_err_len
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CH_W-1:0] grant_q, grant_d;
  logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]      beat_cnt_q, beat_cnt_d;
  logic            err_len_q, err_len_d;

  logic [ADDR_W-1:0] araddr_s  [NUM_CH];
  logic [7:0]        arlen_s   [NUM_CH];
  logic [2:0]        arsize_s  [NUM_CH];
  logic [1:0]        arburst_s [NUM_CH];

  logic            found_s;
  logic [CH_W-1:0] pick_s;
  logic [CH_W-1:0] cand_s;
  logic [CH_W-1:0] grant_next_s;
  logic            r_hs_s;

  // Unpack the per-channel AR field buses into arrays indexed by channel.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      araddr_s[k]  = I_ch_araddr[k*ADDR_W +: ADDR_W];
      arlen_s[k]   = I_ch_arlen[k*8 +: 8];
      arsize_s[k]  = I_ch_arsize[k*3 +: 3];
      arburst_s[k] = I_ch_arburst[k*2 +: 2];
    end
  end

  // Cyclic search for the first requesting channel at or after rr_ptr.
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    cand_s  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand_s = CH_W'((int'(rr_ptr_q) + i) % NUM_CH);
      if (!found_s && I_ch_arvalid[cand_s]) begin
        found_s = 1'b1;
        pick_s  = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Channel after the current grant, wrapping at NUM_CH-1 (also for non power-of-two NUM_CH).
  always_comb begin
    if (grant_q == CH_W'(NUM_CH - 1)) begin
      grant_next_s = '0;
    end else begin
      grant_next_s = grant_q + CH_W'(1);
    end
  end

  assign r_hs_s = (state_q == ST_R) && I_axi_rvalid && I_ch_rready[grant_q];

  // Next-state logic: grant in IDLE, address phase in AR, beat counting in R.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    err_len_d  = err_len_q;
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          grant_d = pick_s;
          state_d = ST_AR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_AR: begin
        if (I_axi_arready) begin
          beat_cnt_d = arlen_s[grant_q];
          state_d    = ST_R;
        end else begin
          state_d = ST_AR;
        end
      end
      ST_R: begin
        if (r_hs_s) begin
          if (I_axi_rlast) begin
            // The last beat must land exactly when the remaining count reaches zero.
            if (beat_cnt_q != 8'd0) begin
              err_len_d = 1'b1;
            end else begin
              err_len_d = err_len_q;
            end
            rr_ptr_d = grant_next_s;
            state_d  = ST_IDLE;
          end else if (beat_cnt_q == 8'd0) begin
            // Slave overran ARLEN: flag it, keep counter at zero, keep transferring.
            err_len_d = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q - 8'd1;
          end
        end else begin
          state_d = ST_R;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and bookkeeping registers with asynchronous active-low reset.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= 8'd0;
      err_len_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      err_len_q  <= err_len_d;
    end
  end

  // Route handshakes between the granted channel and the downstream port.
  always_comb begin
    O_ch_arready  = '0;
    O_ch_rvalid   = '0;
    O_ch_rlast    = '0;
    O_ch_rdata    = '0;
    O_axi_arvalid = 1'b0;
    O_axi_araddr  = '0;
    O_axi_arlen   = 8'd0;
    O_axi_arsize  = 3'd0;
    O_axi_arburst = 2'd0;
    O_axi_rready  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        O_axi_arvalid = 1'b0;
      end
      ST_AR: begin
        O_axi_arvalid         = 1'b1;
        O_axi_araddr          = araddr_s[grant_q];
        O_axi_arlen           = arlen_s[grant_q];
        O_axi_arsize          = arsize_s[grant_q];
        O_axi_arburst         = arburst_s[grant_q];
        O_ch_arready[grant_q] = I_axi_arready;
      end
      ST_R: begin
        O_axi_rready         = I_ch_rready[grant_q];
        O_ch_rvalid[grant_q] = I_axi_rvalid;
        O_ch_rlast[grant_q]  = I_axi_rlast;
        O_ch_rdata           = I_axi_rdata;
      end
      default: begin
        O_axi_arvalid = 1'b0;
      end
    endcase
  end

  assign O_busy    = (state_q != ST_IDLE);
  assign O_grant   = grant_q;
  assign O_err_len = err_len_q;

endmodule

// File: tb/tb_ysyx_22040750_axi_rd_arbiter_n.sv
// Directed self-checking bench for the N-channel AXI read arbiter (NUM_CH=4).
module tb_ysyx_22040750_axi_rd_arbiter_n;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int CH_W   = 2;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_CH-1:0]        ch_arvalid;
  logic [NUM_CH-1:0]        ch_arready;
  logic [NUM_CH*ADDR_W-1:0] ch_araddr;
  logic [NUM_CH*8-1:0]      ch_arlen;
  logic [NUM_CH*3-1:0]      ch_arsize;
  logic [NUM_CH*2-1:0]      ch_arburst;
  logic [NUM_CH-1:0]        ch_rvalid;
  logic [NUM_CH-1:0]        ch_rready;
  logic [DATA_W-1:0]        ch_rdata;
  logic [NUM_CH-1:0]        ch_rlast;
  logic                     axi_arvalid;
  logic                     axi_arready;
  logic [ADDR_W-1:0]        axi_araddr;
  logic [7:0]               axi_arlen;
  logic [2:0]               axi_arsize;
  logic [1:0]               axi_arburst;
  logic                     axi_rvalid;
  logic                     axi_rready;
  logic [DATA_W-1:0]        axi_rdata;
  logic                     axi_rlast;
  logic                     busy;
  logic [CH_W-1:0]          grant;
  logic                     err_len;

  int n_tests = 0;
  int n_fail  = 0;

  ysyx_22040750_axi_rd_arbiter_n #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .I_clk(clk), .I_rst_n(rst_n),
    .I_ch_arvalid(ch_arvalid), .O_ch_arready(ch_arready),
    .I_ch_araddr(ch_araddr), .I_ch_arlen(ch_arlen),
    .I_ch_arsize(ch_arsize), .I_ch_arburst(ch_arburst),
    .O_ch_rvalid(ch_rvalid), .I_ch_rready(ch_rready),
    .O_ch_rdata(ch_rdata), .O_ch_rlast(ch_rlast),
    .O_axi_arvalid(axi_arvalid), .I_axi_arready(axi_arready),
    .O_axi_araddr(axi_araddr), .O_axi_arlen(axi_arlen),
    .O_axi_arsize(axi_arsize), .O_axi_arburst(axi_arburst),
    .I_axi_rvalid(axi_rvalid), .O_axi_rready(axi_rready),
    .I_axi_rdata(axi_rdata), .I_axi_rlast(axi_rlast),
    .O_busy(busy), .O_grant(grant), .O_err_len(err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clear_inputs();
    ch_arvalid  = '0;
    ch_araddr   = '0;
    ch_arlen    = '0;
    ch_arsize   = '0;
    ch_arburst  = '0;
    ch_rready   = '0;
    axi_arready = 1'b0;
    axi_rvalid  = 1'b0;
    axi_rdata   = '0;
    axi_rlast   = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_ar(input int ch, input logic [31:0] addr, input logic [7:0] len);
    ch_araddr[ch*ADDR_W +: ADDR_W] = addr;
    ch_arlen[ch*8 +: 8]            = len;
    ch_arsize[ch*3 +: 3]           = 3'd3;
    ch_arburst[ch*2 +: 2]          = 2'd1;
    ch_arvalid[ch]                 = 1'b1;
  endtask

  // Full burst on channel ch: waits for AR, handshakes after ar_delay cycles,
  // then drives nbeats beats (rlast on the final one), optionally toggling rready.
  task automatic run_burst(input int ch, input logic [7:0] len, input int nbeats,
                           input int ar_delay, input bit toggle, input bit hold);
    int   waited;
    int   b;
    int   cyc;
    logic [63:0] data;
    logic [NUM_CH-1:0] onehot;
    onehot = NUM_CH'(1) << ch;
    waited = 0;
    @(negedge clk); #1;
    while (!axi_arvalid && waited < 20) begin
      @(negedge clk); #1;
      waited++;
    end
    check_eq("ar_seen", {63'd0, axi_arvalid}, 64'd1);
    check_eq("grant", {62'd0, grant}, 64'(ch));
    check_eq("arlen_mux", {56'd0, axi_arlen}, {56'd0, len});
    for (int d = 0; d < ar_delay; d++) begin
      check_eq("arready_idle", {60'd0, ch_arready}, 64'd0);
      @(negedge clk); #1;
      check_eq("ar_held", {63'd0, axi_arvalid}, 64'd1);
    end
    axi_arready = 1'b1;
    #1;
    check_eq("arready_route", {60'd0, ch_arready}, {60'd0, onehot});
    @(negedge clk);
    axi_arready = 1'b0;
    if (!hold) ch_arvalid[ch] = 1'b0;
    b   = 0;
    cyc = 0;
    while (b < nbeats && cyc < 64) begin
      data         = {32'hD000_0000 | 32'(ch), 32'(b)};
      axi_rvalid   = 1'b1;
      axi_rdata    = data;
      axi_rlast    = (b == nbeats - 1);
      ch_rready[ch] = toggle ? (cyc % 2 == 0) : 1'b1;
      #1;
      check_eq("rvalid_route", {60'd0, ch_rvalid}, {60'd0, onehot});
      check_eq("rready_mirror", {63'd0, axi_rready}, {63'd0, ch_rready[ch]});
      check_eq("rdata", ch_rdata, data);
      check_eq("busy_in_r", {63'd0, busy}, 64'd1);
      if (ch_rready[ch]) b++;
      cyc++;
      @(negedge clk);
    end
    check_eq("beats_done", 64'(b), 64'(nbeats));
    axi_rvalid = 1'b0;
    axi_rlast  = 1'b0;
    ch_rready  = '0;
    #1;
    check_eq("busy_after", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int order [5];
    order = '{3, 0, 1, 2, 3};
    rst_n = 1'b1;
    clear_inputs();
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_grant", {62'd0, grant}, 64'd0);
    check_eq("rst_err", {63'd0, err_len}, 64'd0);
    check_eq("rst_arvalid", {63'd0, axi_arvalid}, 64'd0);
    check_eq("rst_rdata", ch_rdata, 64'd0);
    do_reset();

    // 1: ch2 alone, arlen=3, four beats. Check 1-cycle AR latency and address.
    set_ar(2, 32'h8000_0010, 8'd3);
    #1;
    check_eq("ar_latency0", {63'd0, axi_arvalid}, 64'd0);
    @(negedge clk); #1;
    check_eq("ar_latency1", {63'd0, axi_arvalid}, 64'd1);
    check_eq("araddr", {32'd0, axi_araddr}, 64'h8000_0010);
    run_burst(2, 8'd3, 4, 0, 1'b0, 1'b0);
    check_eq("t1_grant", {62'd0, grant}, 64'd2);
    check_eq("t1_err", {63'd0, err_len}, 64'd0);

    // 2: all channels hold requests; rr_ptr=3 after test 1, so 3,0,1,2,3.
    for (int c = 0; c < NUM_CH; c++) set_ar(c, 32'h1000_0000 + 32'(c * 64), 8'd0);
    for (int k = 0; k < 5; k++) run_burst(order[k], 8'd0, 1, 0, 1'b0, 1'b1);
    ch_arvalid = '0;

    // 3: ch1, arready delayed 5 cycles, rready toggling during 4-beat burst.
    set_ar(1, 32'h2000_0040, 8'd3);
    run_burst(1, 8'd3, 4, 5, 1'b1, 1'b0);
    check_eq("t3_err", {63'd0, err_len}, 64'd0);

    // 4: arlen=3 but rlast on beat 2 -> sticky error across a clean burst.
    set_ar(0, 32'h3000_0000, 8'd3);
    run_burst(0, 8'd3, 2, 0, 1'b0, 1'b0);
    check_eq("t4_err", {63'd0, err_len}, 64'd1);
    set_ar(3, 32'h3000_0100, 8'd0);
    run_burst(3, 8'd0, 1, 0, 1'b0, 1'b0);
    check_eq("t4_err_sticky", {63'd0, err_len}, 64'd1);

    // 5: after reset, arlen=1 with three beats -> error, burst still completes.
    do_reset();
    check_eq("t5_err_clr", {63'd0, err_len}, 64'd0);
    set_ar(1, 32'h4000_0000, 8'd1);
    run_burst(1, 8'd1, 3, 0, 1'b0, 1'b0);
    check_eq("t5_err", {63'd0, err_len}, 64'd1);

    // 6: asynchronous reset in the middle of R, then ch3 alone.
    set_ar(2, 32'h5000_0000, 8'd3);
    repeat (2) @(negedge clk);
    axi_arready = 1'b1;
    @(negedge clk);
    axi_arready = 1'b0;
    ch_arvalid  = '0;
    axi_rvalid  = 1'b1;
    axi_rdata   = 64'hCAFE_F00D_0000_0001;
    ch_rready[2] = 1'b1;
    #1;
    check_eq("t6_in_r", {60'd0, ch_rvalid}, 64'h4);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_rst_busy", {63'd0, busy}, 64'd0);
    check_eq("t6_rst_rvalid", {60'd0, ch_rvalid}, 64'd0);
    check_eq("t6_rst_rready", {63'd0, axi_rready}, 64'd0);
    check_eq("t6_rst_rdata", ch_rdata, 64'd0);
    check_eq("t6_rst_grant", {62'd0, grant}, 64'd0);
    check_eq("t6_rst_err", {63'd0, err_len}, 64'd0);
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    set_ar(3, 32'h6000_0000, 8'd0);
    run_burst(3, 8'd0, 1, 0, 1'b0, 1'b0);
    // rr_ptr is now 0: ch1 and ch2 together -> ch1 wins.
    set_ar(1, 32'h7000_0000, 8'd0);
    set_ar(2, 32'h7000_0040, 8'd0);
    run_burst(1, 8'd0, 1, 0, 1'b0, 1'b0);
    run_burst(2, 8'd0, 1, 0, 1'b0, 1'b0);
    check_eq("t6_err", {63'd0, err_len}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
